// File: rtl/resource_responder.sv
// Responder for the resource request protocol: round-robin grant over n_ports
// initiators, fixed-latency read or read-modify-write against a shared bank.
module resource_responder #(
  parameter int unsigned data_width   = 16,
  parameter int unsigned handle_width = 8,
  parameter int unsigned n_ports      = 2
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic [n_ports-1:0]               read_req,
  input  logic [n_ports-1:0]               write_req,
  input  logic [n_ports*handle_width-1:0]  handle,
  input  logic [n_ports*data_width-1:0]    arg_a,
  input  logic [n_ports*data_width-1:0]    arg_b,
  output logic [n_ports*data_width-1:0]    data_out,
  output logic [n_ports-1:0]               read_ready,
  output logic [n_ports-1:0]               write_ack,
  input  logic                             ext_valid,
  output logic                             ext_ready,
  input  logic [handle_width-1:0]          ext_handle,
  input  logic [data_width-1:0]            ext_data
);

  localparam int unsigned pw    = (n_ports > 1) ? $clog2(n_ports) : 1;
  localparam int unsigned depth = 2 ** handle_width;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state;
  logic [pw-1:0]           last_grant;
  logic [pw-1:0]           g_port;
  logic [handle_width-1:0] g_handle;
  logic [data_width-1:0]   g_arg_a;
  logic                    g_accum;
  logic                    g_write;
  logic [data_width-1:0]   rd_word;
  logic [data_width-1:0]   commit_word;
  logic [data_width:0]     acc_sum;
  logic [data_width-1:0]   bank [depth];

  logic                    arb_valid;
  logic [pw-1:0]           arb_port;
  logic [pw-1:0]           cand;
  logic                    ext_take;
  logic                    unused_arg_b;

  assign ext_ready    = (state == IDLE) && enable;
  assign ext_take     = ext_ready && ext_valid;
  assign unused_arg_b = ^arg_b;

  // First requester strictly after last_grant, wrapping around.
  always_comb begin
    arb_valid = 1'b0;
    arb_port  = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= n_ports; i++) begin
      cand = pw'((32'(last_grant) + i) % n_ports);
      if (!arb_valid && (read_req[cand] || write_req[cand])) begin
        arb_valid = 1'b1;
        arb_port  = cand;
      end
    end
  end

  // Accumulate at data_width+1 bits; disagreeing top bits mean overflow.
  always_comb begin
    acc_sum = {rd_word[data_width-1], rd_word} + {g_arg_a[data_width-1], g_arg_a};
    if (!g_accum)
      commit_word = g_arg_a;
    else if (acc_sum[data_width] != acc_sum[data_width-1])
      commit_word = acc_sum[data_width] ? {1'b1, {(data_width-1){1'b0}}}
                                        : {1'b0, {(data_width-1){1'b1}}};
    else
      commit_word = acc_sum[data_width-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset_n && enable) begin
      if (ext_take)
        bank[ext_handle] <= ext_data;
      else if (state == RESP && g_write)
        bank[g_handle] <= commit_word;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= pw'(n_ports - 1);
      g_port     <= '0;
      g_handle   <= '0;
      g_arg_a    <= '0;
      g_accum    <= 1'b0;
      g_write    <= 1'b0;
      rd_word    <= '0;
      data_out   <= '0;
      read_ready <= '0;
      write_ack  <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (!ext_valid && arb_valid) begin
            g_port   <= arb_port;
            g_handle <= handle[32'(arb_port)*handle_width +: handle_width];
            g_arg_a  <= arg_a[32'(arb_port)*data_width +: data_width];
            g_accum  <= arg_b[32'(arb_port)*data_width];
            g_write  <= write_req[arb_port];
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          rd_word <= bank[g_handle];
          if (g_write) begin
            write_ack[g_port] <= 1'b1;
          end else begin
            read_ready[g_port] <= 1'b1;
            data_out[32'(g_port)*data_width +: data_width] <= bank[g_handle];
          end
          state <= RESP;
        end
        RESP: begin
          read_ready <= '0;
          write_ack  <= '0;
          last_grant <= g_port;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/resource_responder.md
# resource_responder

Responder end of the resource request protocol: serves `read_req`/`write_req` handshakes from up to `n_ports` resource-branch initiators against a shared signed register bank of `2**handle_width` words. It arbitrates round-robin, performs a fixed-latency read or read-modify-write, and answers with a one-cycle `read_ready` or `write_ack` pulse on the granted port. A host-side external port loads bank contents between requests.

## Interface
- `data_width`, 16, word width; signed two's complement.
- `handle_width`, 8, bank address width; the bank depth is `2**handle_width`.
- `n_ports`, 2, number of initiator ports (≥1). Per-port signals are flattened, with port p at slice p.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, state, outputs and the bank hold, and no new grant is made.
- `read_req` in n_ports: per-port read request, level, held until `read_ready`.
- `write_req` in n_ports: per-port write request, level, held until `write_ack`.
- `handle` in n_ports×handle_width: bank address.
- `arg_a` in n_ports×data_width: write operand.
- `arg_b` in n_ports×data_width: write mode. `arg_b[0]`=1 selects saturating accumulate; otherwise plain store.
- `data_out` out n_ports×data_width: read result; valid while `read_ready`.
- `read_ready` out n_ports: one-cycle read completion pulse.
- `write_ack` out n_ports: one-cycle write completion pulse.
- `ext_valid` in 1: host write request.
- `ext_ready` out 1: host write accepted this cycle.
- `ext_handle` in handle_width: host write address.
- `ext_data` in data_width: host write data.

## Operation
- FSM with three states: IDLE, ACCESS, RESP.
- **IDLE**
  - If `ext_valid`, the bank takes `ext_data` at `ext_handle` this edge. `ext_ready` = (state==IDLE) & enable.
  - The host has priority: no grant is made in a cycle where an ext write is taken.
  - Otherwise, if any port p has `read_req|write_req`, grant the first requesting port after `last_grant` in rotating order.
  - On a grant, latch port index, handle, `arg_a`, `arg_b`, and whether it is a write. A port asserting both requests is treated as a write. Go to ACCESS.
- **ACCESS**
  - Bank read of the latched handle; the result is registered at the end of the cycle. Go to RESP.
- **RESP**
  - Read: drive `data_out[p]` with the bank word and pulse `read_ready[p]`.
  - Write: pulse `write_ack[p]` and commit to the bank at the end of this cycle:
    - Plain store: `arg_a`.
    - Accumulate: bank word + `arg_a`, computed at data_width+1 bits and clamped to [−2^(data_width−1), 2^(data_width−1)−1].
  - Update `last_grant` ← p. Go to IDLE.
- Only the granted port ever sees `read_ready`/`write_ack`; all other ports' pulses stay 0.
- `data_out[p]` holds its last read value until the next read completion on that port.
- Re-service guard: an initiator drops its request the cycle after the pulse. RESP → IDLE does not arbitrate in the RESP cycle, so the same request is never served twice.
- Reset (asynchronous, any state):
  - State returns to IDLE; `last_grant` = n_ports−1, so port 0 wins first.
  - All `read_ready`, `write_ack` and `data_out` are 0; `ext_ready` evaluates from IDLE.
  - Bank contents are not reset.
  - An in-flight write aborted by reset is not committed and not acknowledged.

## Timing
- Grant edge at cycle 0 (IDLE, request seen). ACCESS is cycle 1. RESP is cycle 2, with the pulse high for exactly that cycle.
- Next grant is possible at the earliest in cycle 3, giving 3 cycles per transaction.
- Read-after-write to the same handle from any port returns the new value: the write commits at the RESP edge, and a following ACCESS is at least 2 cycles later.
- Ext write taken in cycle c is visible to an ACCESS in cycle c+2 or later. A request pending in cycle c is granted at the earliest in cycle c+1.
- `enable` low freezes the current cycle. Pulses stay asserted while frozen in RESP, and no bank write occurs until `enable` returns.

## Test plan
- Ext write handle 0x05 = 0x1234. Port 0 then reads 0x05 → `read_ready[0]` high 2 cycles after the grant, for 1 cycle, with `data_out[0]`=0x1234. Port 1 pulses stay 0.
- Ports 0 and 1 both hold `read_req` continuously, 4 transactions → grants alternate 0,1,0,1, starting with port 0 after reset.
- Port 1 writes 0x7FF0 to handle 0x10, then accumulates `arg_a`=0x0020 with `arg_b`=1 → `write_ack[1]` pulses twice. A read of 0x10 returns 0x7FFF (saturated). Accumulating −0x8000 + −1 yields −0x8000.
- `ext_valid` and `read_req[0]` both rise in the same IDLE cycle → `ext_ready`=1 and the ext write is taken. Port 0 is granted next cycle and returns the ext-written value.
- `reset_n` pulsed low during ACCESS of a write → outputs are 0 immediately, `write_ack` never pulses, and the bank word is unchanged.
- `enable` held low for 5 cycles during RESP → `read_ready` stays high all 5 cycles with stable `data_out`, and the FSM resumes to IDLE after `enable` rises.
